// File: rtl/mole_spawner_if.sv
// rtl/mole_spawner_if.sv - spawn request, hit and mole status bundle for mole_spawner
interface mole_spawner_if #(
  parameter int HOLES = 9
);
  logic [31:0]      random;
  logic             tick;
  logic             spawn_req;
  logic [HOLES-1:0] hit;
  logic             busy;
  logic             spawn_ack;
  logic             spawn_fail;
  logic [3:0]       spawn_hole;
  logic [HOLES-1:0] mole;
  logic [HOLES-1:0] hit_ok;
  logic [HOLES-1:0] hit_bad;
  logic [HOLES-1:0] miss;
  logic [4:0]       active_cnt;

  // DUT side
  modport slave (
    input  random, tick, spawn_req, hit,
    output busy, spawn_ack, spawn_fail, spawn_hole, mole, hit_ok, hit_bad, miss, active_cnt
  );

  // game / score logic side
  modport master (
    output random, tick, spawn_req, hit,
    input  busy, spawn_ack, spawn_fail, spawn_hole, mole, hit_ok, hit_bad, miss, active_cnt
  );
endinterface

// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - places moles in free holes from a PRNG stream and times their lives
module mole_spawner #(
  parameter int HOLES      = 9,
  parameter int LIFE_MIN   = 200,
  parameter int LIFE_BITS  = 8,
  parameter int MAX_ACTIVE = 3,
  parameter int MAX_TRY    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mole_spawner_if.slave bus
);
  localparam int TW = $clog2(MAX_TRY + 1);

  typedef enum logic [1:0] {IDLE, PICK, LOAD} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [3:0]       cand_q, cand_d;
  logic [15:0]      life_q, life_d;
  logic             ack_q, ack_d;
  logic             fail_q, fail_d;
  logic [3:0]       hole_q, hole_d;
  logic [HOLES-1:0] mole_q, mole_d;
  logic [15:0]      cnt_q [HOLES];
  logic [15:0]      cnt_d [HOLES];
  logic [HOLES-1:0] hit_ok_q, hit_ok_d;
  logic [HOLES-1:0] hit_bad_q, hit_bad_d;
  logic [HOLES-1:0] miss_q, miss_d;
  logic [4:0]       active_q, active_d;

  logic [3:0]       samp;
  logic [15:0]      occ16;
  logic             pick_ok;
  logic             unused_random;

  // Holes beyond HOLES read as occupied-irrelevant zeros; the range check rejects them first.
  assign samp          = bus.random[3:0];
  assign occ16         = 16'(mole_q);
  assign pick_ok       = ({1'b0, samp} < 5'(HOLES)) && !occ16[samp];
  assign unused_random = ^{bus.random[31:24], bus.random[15:4]};

  // Request FSM: idle -> rejection sampling -> one-cycle load.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    cand_d  = cand_q;
    life_d  = life_q;
    hole_d  = hole_q;
    ack_d   = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.spawn_req) begin
          if (active_q == 5'(MAX_ACTIVE)) begin
            fail_d = 1'b1;
          end else begin
            state_d = PICK;
            tries_d = '0;
          end
        end
      end
      PICK: begin
        if (pick_ok) begin
          cand_d  = samp;
          life_d  = 16'(LIFE_MIN) + 16'(bus.random[16 +: LIFE_BITS]);
          hole_d  = samp;
          ack_d   = 1'b1;
          state_d = LOAD;
        end else begin
          tries_d = tries_q + TW'(1);
          if (tries_d == TW'(MAX_TRY)) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-hole life timing; a hit beats an expiring tick, and a hit during LOAD sees the empty hole.
  always_comb begin
    mole_d    = mole_q;
    hit_ok_d  = '0;
    hit_bad_d = '0;
    miss_d    = '0;
    active_d  = '0;
    for (int i = 0; i < HOLES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (mole_q[i]) begin
        if (bus.hit[i]) begin
          mole_d[i]   = 1'b0;
          cnt_d[i]    = '0;
          hit_ok_d[i] = 1'b1;
        end else if (bus.tick) begin
          cnt_d[i] = cnt_q[i] - 16'd1;
          if (cnt_q[i] == 16'd1) begin
            mole_d[i] = 1'b0;
            miss_d[i] = 1'b1;
          end
        end
      end else begin
        hit_bad_d[i] = bus.hit[i];
        if ((state_q == LOAD) && (cand_q == 4'(i))) begin
          mole_d[i] = 1'b1;
          cnt_d[i]  = life_q;
        end
      end
      active_d = active_d + 5'(mole_q[i]);
    end
  end

  // State and output registers; reset aborts any request or life in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tries_q   <= '0;
      cand_q    <= '0;
      life_q    <= '0;
      hole_q    <= '0;
      ack_q     <= 1'b0;
      fail_q    <= 1'b0;
      mole_q    <= '0;
      hit_ok_q  <= '0;
      hit_bad_q <= '0;
      miss_q    <= '0;
      active_q  <= '0;
      for (int i = 0; i < HOLES; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      cand_q    <= cand_d;
      life_q    <= life_d;
      hole_q    <= hole_d;
      ack_q     <= ack_d;
      fail_q    <= fail_d;
      mole_q    <= mole_d;
      hit_ok_q  <= hit_ok_d;
      hit_bad_q <= hit_bad_d;
      miss_q    <= miss_d;
      active_q  <= active_d;
      for (int i = 0; i < HOLES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.spawn_ack  = ack_q;
  assign bus.spawn_fail = fail_q;
  assign bus.spawn_hole = hole_q;
  assign bus.mole       = mole_q;
  assign bus.hit_ok     = hit_ok_q;
  assign bus.hit_bad    = hit_bad_q;
  assign bus.miss       = miss_q;
  assign bus.active_cnt = active_q;
endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - directed self-checking bench for mole_spawner
module tb_mole_spawner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  logic [31:0] seen;

  mole_spawner_if #(.HOLES(9)) bus ();

  mole_spawner #(
    .HOLES(9), .LIFE_MIN(200), .LIFE_BITS(8), .MAX_ACTIVE(3), .MAX_TRY(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  // Issue a request with a fixed random word, wait (bounded) for ack, then let LOAD and active_cnt settle.
  task automatic place(input logic [31:0] r, output int l);
    bus.random    = r;
    bus.spawn_req = 1'b1;
    step();
    bus.spawn_req = 1'b0;
    l = 1;
    while (!bus.spawn_ack && l < 40) begin
      step();
      l++;
    end
    step();
    step();
  endtask

  initial begin
    bus.random    = '0;
    bus.tick      = 1'b0;
    bus.spawn_req = 1'b0;
    bus.hit       = '0;
    step();
    step();
    check("rst_mole", 32'(bus.mole), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_hole", 32'(bus.spawn_hole), 32'h0);
    check("rst_cnt", 32'(bus.active_cnt), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: first sample accepted, hole 3, life 205
    bus.random    = 32'h0005_0003;
    bus.spawn_req = 1'b1;
    step();
    bus.spawn_req = 1'b0;
    check("t1_busy_pick", 32'(bus.busy), 32'h1);
    check("t1_ack_early", 32'(bus.spawn_ack), 32'h0);
    step();
    check("t1_ack", 32'(bus.spawn_ack), 32'h1);
    check("t1_hole", 32'(bus.spawn_hole), 32'h3);
    step();
    check("t1_ack_width", 32'(bus.spawn_ack), 32'h0);
    check("t1_mole", 32'(bus.mole), 32'h008);
    check("t1_busy_done", 32'(bus.busy), 32'h0);
    step();
    check("t1_active", 32'(bus.active_cnt), 32'h1);
    seen = '0;
    for (int i = 0; i < 204; i++) begin
      do_tick();
      seen = seen | 32'(bus.miss);
    end
    check("t1_no_early_miss", seen, 32'h0);
    check("t1_mole_204", 32'(bus.mole), 32'h008);
    do_tick();
    check("t1_miss_205", 32'(bus.miss), 32'h008);
    check("t1_mole_gone", 32'(bus.mole), 32'h0);
    step();
    check("t1_miss_width", 32'(bus.miss), 32'h0);

    // 2: F and C rejected, 2 accepted, latency 4
    bus.random    = 32'h0000_000F;
    bus.spawn_req = 1'b1;
    step();
    bus.spawn_req = 1'b0;
    step();
    check("t2_ack_c2", 32'(bus.spawn_ack), 32'h0);
    bus.random = 32'h0000_000C;
    step();
    check("t2_ack_c3", 32'(bus.spawn_ack), 32'h0);
    bus.random = 32'h0000_0002;
    step();
    check("t2_ack_c4", 32'(bus.spawn_ack), 32'h1);
    check("t2_hole", 32'(bus.spawn_hole), 32'h2);
    step();
    check("t2_mole", 32'(bus.mole), 32'h004);

    // 3: out-of-range samples only -> fail 16 cycles after PICK entry
    bus.random    = 32'h0000_000A;
    bus.spawn_req = 1'b1;
    step();
    bus.spawn_req = 1'b0;
    lat = 0;
    while (!bus.spawn_fail && lat < 40) begin
      step();
      lat++;
    end
    check("t3_fail_lat", 32'(lat), 32'd16);
    check("t3_mole", 32'(bus.mole), 32'h004);
    check("t3_busy", 32'(bus.busy), 32'h0);
    step();
    check("t3_fail_width", 32'(bus.spawn_fail), 32'h0);

    // 4: fill to MAX_ACTIVE, fourth request fails without PICK
    place(32'h0000_0000, lat);
    check("t4_lat0", 32'(lat), 32'd2);
    place(32'h0000_0005, lat);
    check("t4_lat5", 32'(lat), 32'd2);
    check("t4_mole", 32'(bus.mole), 32'h025);
    check("t4_active", 32'(bus.active_cnt), 32'h3);
    bus.random    = 32'h0000_0001;
    bus.spawn_req = 1'b1;
    step();
    bus.spawn_req = 1'b0;
    check("t4_fail", 32'(bus.spawn_fail), 32'h1);
    check("t4_no_pick", 32'(bus.busy), 32'h0);
    step();
    check("t4_mole_kept", 32'(bus.mole), 32'h025);
    check("t4_active_kept", 32'(bus.active_cnt), 32'h3);

    // 5: hit beats expiry on hole 4, bad hit on empty hole 0, holes 2 and 5 expire together
    bus.hit = 9'h001;
    step();
    bus.hit = '0;
    check("t5_hit0_ok", 32'(bus.hit_ok), 32'h001);
    step();
    check("t5_mole_after_hit", 32'(bus.mole), 32'h024);
    place(32'h0000_0004, lat);
    check("t5_mole4", 32'(bus.mole), 32'h034);
    seen = '0;
    for (int i = 0; i < 199; i++) begin
      do_tick();
      seen = seen | 32'(bus.miss);
    end
    check("t5_no_early_miss", seen, 32'h0);
    bus.hit  = 9'h011;
    bus.tick = 1'b1;
    step();
    bus.hit  = '0;
    bus.tick = 1'b0;
    check("t5_hit_ok", 32'(bus.hit_ok), 32'h010);
    check("t5_hit_bad", 32'(bus.hit_bad), 32'h001);
    check("t5_miss", 32'(bus.miss), 32'h024);
    check("t5_mole_clear", 32'(bus.mole), 32'h0);
    step();
    check("t5_active", 32'(bus.active_cnt), 32'h0);
    check("t5_hit_width", 32'(bus.hit_ok), 32'h0);

    // LOAD cycle hit on the loading hole: bad hit, mole still placed
    bus.random    = 32'h0000_0007;
    bus.spawn_req = 1'b1;
    step();
    bus.spawn_req = 1'b0;
    step();
    check("t5_load_ack", 32'(bus.spawn_ack), 32'h1);
    bus.hit = 9'h080;
    step();
    bus.hit = '0;
    check("t5_load_hit_bad", 32'(bus.hit_bad), 32'h080);
    check("t5_load_hit_ok", 32'(bus.hit_ok), 32'h0);
    check("t5_load_mole", 32'(bus.mole), 32'h080);

    // 6: asynchronous reset during PICK with a mole up
    step();
    bus.random    = 32'h0000_000A;
    bus.spawn_req = 1'b1;
    step();
    bus.spawn_req = 1'b0;
    check("t6_busy_pick", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_mole", 32'(bus.mole), 32'h0);
    check("t6_rst_busy", 32'(bus.busy), 32'h0);
    check("t6_rst_cnt", 32'(bus.active_cnt), 32'h0);
    check("t6_rst_hole", 32'(bus.spawn_hole), 32'h0);
    step();
    rst_n      = 1'b1;
    bus.random = 32'h0000_0001;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      bus.tick = 1'(i % 2);
      step();
      seen = seen | 32'(bus.spawn_ack) | 32'(bus.spawn_fail) | 32'(bus.miss) | 32'(bus.hit_ok);
    end
    bus.tick = 1'b0;
    check("t6_no_pulses", seen, 32'h0);
    check("t6_mole_after", 32'(bus.mole), 32'h0);
    check("t6_busy_after", 32'(bus.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
